// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between DEPTH producers, the round-robin arbiter and one consumer.
// "slave" is the arbiter's view; "master" is the producer/consumer environment.
interface mux_rr_arbiter_if #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int SEL_WIDTH = $clog2(DEPTH)
);
    logic [DEPTH-1:0]           in_valid;
    logic [DEPTH-1:0]           in_ready;
    logic [BIT_WIDTH*DEPTH-1:0] in_data;
    logic [DEPTH-1:0]           in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [BIT_WIDTH-1:0]       out_data;
    logic                       out_last;
    logic [SEL_WIDTH-1:0]       out_sel;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with optional packet lock feeding a single registered output beat.
// One beat per cycle sustained; a beat accepted in cycle N is on out_* in cycle N+1.
module mux_rr_arbiter #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int SEL_WIDTH = $clog2(DEPTH),
    parameter bit LOCK_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus,
    output logic             busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [SEL_WIDTH-1:0] owner, owner_nxt;
    logic [SEL_WIDTH-1:0] winner, pick;
    logic                 load, xfer, beat_last;
    logic [DEPTH-1:0]     grant;
    logic [BIT_WIDTH-1:0] beat_data;

    logic                 vld_p1;
    logic [BIT_WIDTH-1:0] data_p1;
    logic                 last_p1;
    logic [SEL_WIDTH-1:0] sel_p1;

    function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] v);
        if (v == SEL_WIDTH'(DEPTH - 1))
            return '0;
        return v + SEL_WIDTH'(1);
    endfunction

    // Lowest valid index at or above rr_ptr wins; otherwise the lowest valid index below it.
    always_comb begin
        logic                 hi_hit;
        logic [SEL_WIDTH-1:0] hi_idx, lo_idx, iw;
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        iw     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            iw = SEL_WIDTH'(i);
            if (bus.in_valid[iw]) begin
                if (iw >= rr_ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = iw;
                end else begin
                    lo_idx = iw;
                end
            end
        end
        winner = hi_hit ? hi_idx : lo_idx;
    end

    // A locked owner is the only candidate; reset masks every grant.
    always_comb begin
        load  = ~vld_p1 | bus.out_ready;
        pick  = (state == BUSY) ? owner : winner;
        grant = '0;
        if (rst_n && load && bus.in_valid[pick])
            grant[pick] = 1'b1;
        xfer = |grant;
    end

    always_comb begin
        logic [SEL_WIDTH-1:0] iw;
        iw        = '0;
        beat_data = '0;
        beat_last = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            iw = SEL_WIDTH'(i);
            if (pick == iw) begin
                beat_data = bus.in_data[i*BIT_WIDTH +: BIT_WIDTH];
                if (LOCK_EN)
                    beat_last = bus.in_last[iw];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (!beat_last) begin
                        state_nxt = BUSY;
                        owner_nxt = winner;
                    end else begin
                        rr_ptr_nxt = wrap_inc(winner);
                    end
                end
                BUSY: begin
                    if (beat_last) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = wrap_inc(owner);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // Stage p1: output register; holds while stalled, drops valid only on a drain with no new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            sel_p1  <= '0;
        end else if (load) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= beat_data;
                last_p1 <= beat_last;
                sel_p1  <= pick;
            end
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_sel   = sel_p1;
    assign busy          = (state == BUSY);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: a locked DEPTH=4 instance and an unlocked DEPTH=3 instance,
// both checked every cycle against a queue/modulo-level model, plus literal directed sequences.
`timescale 1ns/1ps
module tb_mux_rr_arbiter;
    localparam int BW = 8;
    localparam int DA = 4;
    localparam int DB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, busy_b;

    logic [3:0]  iv   [2];
    logic [31:0] idat [2];
    logic [3:0]  il   [2];
    logic        ordy [2];

    int n_cmp  = 0;
    int n_fail = 0;

    int m_vld   [2] = '{0, 0};
    int m_data  [2] = '{0, 0};
    int m_last  [2] = '{0, 0};
    int m_sel   [2] = '{0, 0};
    int m_owner [2] = '{-1, -1};
    int m_ptr   [2] = '{0, 0};

    int loga [$];
    int logb [$];

    mux_rr_arbiter_if #(.BIT_WIDTH(BW), .DEPTH(DA)) ifa ();
    mux_rr_arbiter_if #(.BIT_WIDTH(BW), .DEPTH(DB)) ifb ();

    assign ifa.in_valid  = iv[0];
    assign ifa.in_data   = idat[0];
    assign ifa.in_last   = il[0];
    assign ifa.out_ready = ordy[0];
    assign ifb.in_valid  = iv[1][2:0];
    assign ifb.in_data   = idat[1][23:0];
    assign ifb.in_last   = il[1][2:0];
    assign ifb.out_ready = ordy[1];

    mux_rr_arbiter #(.BIT_WIDTH(BW), .DEPTH(DA), .LOCK_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .busy(busy_a));
    mux_rr_arbiter #(.BIT_WIDTH(BW), .DEPTH(DB), .LOCK_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .busy(busy_b));

    always #5 clk = ~clk;

    function automatic int dep(input int d); return (d == 0) ? DA : DB; endfunction
    function automatic int lk(input int d);  return (d == 0) ? 1 : 0;   endfunction

    function automatic int dut_vld(input int d);  return (d == 0) ? int'(ifa.out_valid) : int'(ifb.out_valid); endfunction
    function automatic int dut_data(input int d); return (d == 0) ? int'(ifa.out_data)  : int'(ifb.out_data);  endfunction
    function automatic int dut_last(input int d); return (d == 0) ? int'(ifa.out_last)  : int'(ifb.out_last);  endfunction
    function automatic int dut_sel(input int d);  return (d == 0) ? int'(ifa.out_sel)   : int'(ifb.out_sel);   endfunction
    function automatic int dut_busy(input int d); return (d == 0) ? int'(busy_a)        : int'(busy_b);        endfunction
    function automatic int dut_rdy(input int d);  return (d == 0) ? int'(ifa.in_ready)  : int'(ifb.in_ready);  endfunction

    function automatic int pack(input int last, input int sel, input int data);
        return (last << 16) | (sel << 8) | data;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who may transfer this cycle, from the rules (owner lock, else modular scan from ptr).
    function automatic int exp_ready(input int d);
        int i;
        if (!rst_n) return 0;
        if (m_vld[d] != 0 && !ordy[d]) return 0;
        if (m_owner[d] >= 0)
            return iv[d][m_owner[d]] ? (1 << m_owner[d]) : 0;
        for (int k = 0; k < dep(d); k++) begin
            i = (m_ptr[d] + k) % dep(d);
            if (iv[d][i]) return 1 << i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_proc
        int r, w, lst;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_vld[d] <= 0; m_data[d] <= 0; m_last[d] <= 0;
                m_sel[d] <= 0; m_owner[d] <= -1; m_ptr[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                r = exp_ready(d);
                if (r != 0) begin
                    w = $clog2(r);
                    lst = (lk(d) != 0) ? int'(il[d][w]) : 1;
                    m_vld[d]  <= 1;
                    m_data[d] <= int'(idat[d][w*8 +: 8]);
                    m_last[d] <= lst;
                    m_sel[d]  <= w;
                    if (lst != 0) begin
                        m_owner[d] <= -1;
                        m_ptr[d]   <= (w + 1) % dep(d);
                    end else begin
                        m_owner[d] <= w;
                    end
                end else if (ordy[d]) begin
                    m_vld[d] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp_proc
        string p;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? "a_" : "b_";
            chk({p, "out_valid"}, dut_vld(d), m_vld[d]);
            chk({p, "busy"}, dut_busy(d), (m_owner[d] >= 0) ? 1 : 0);
            chk({p, "in_ready"}, dut_rdy(d), exp_ready(d));
            if (m_vld[d] != 0 || !rst_n) begin
                chk({p, "out_data"}, dut_data(d), m_data[d]);
                chk({p, "out_last"}, dut_last(d), m_last[d]);
                chk({p, "out_sel"}, dut_sel(d), m_sel[d]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifa.out_valid && ordy[0])
            loga.push_back(pack(int'(ifa.out_last), int'(ifa.out_sel), int'(ifa.out_data)));
        if (rst_n && ifb.out_valid && ordy[1])
            logb.push_back(pack(int'(ifb.out_last), int'(ifb.out_sel), int'(ifb.out_data)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        cyc();
        rst_n = 1'b0;
        iv[0] = '0;
        iv[1] = '0;
        cyc();
        rst_n = 1'b1;
    endtask

    // Requesters keep an unaccepted beat stable; otherwise they may offer a fresh one.
    task automatic drive_rand(input int d, input logic [3:0] acc);
        for (int i = 0; i < dep(d); i++) begin
            if (!iv[d][i] || acc[i]) begin
                iv[d][i]          = ($urandom_range(0, 99) < 60);
                idat[d][i*8 +: 8] = 8'($urandom);
                il[d][i]          = ($urandom_range(0, 2) == 0);
            end
        end
        ordy[d] = ($urandom_range(0, 99) < 70);
    endtask

    task automatic chk_log(input string nm, input int got [$], input int exp [$]);
        int act;
        chk({nm, "_count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            act = (k < got.size()) ? got[k] : -1;
            chk($sformatf("%s_beat%0d", nm, k), act, exp[k]);
        end
    endtask

    initial begin
        int         nb;
        int         exp_q [$];
        logic [3:0] acc0, acc1;

        iv[0] = '0; iv[1] = '0; idat[0] = '0; idat[1] = '0;
        il[0] = '0; il[1] = '0; ordy[0] = 1'b0; ordy[1] = 1'b0;

        // Reset held with random inputs
        rst_n = 1'b0;
        repeat (4) begin
            cyc();
            drive_rand(0, 4'hF);
            drive_rand(1, 4'hF);
        end
        @(negedge clk);
        chk("rst_a_valid", int'(ifa.out_valid), 0);
        chk("rst_a_ready", int'(ifa.in_ready), 0);
        chk("rst_b_ready", int'(ifb.in_ready), 0);
        chk("rst_a_busy", int'(busy_a), 0);
        cyc();
        rst_n = 1'b1;
        iv[0] = 4'b0100; il[0] = 4'hF; idat[0] = 32'h33221100; ordy[0] = 1'b1;
        iv[1] = '0; ordy[1] = 1'b1;
        @(negedge clk);
        chk("t1_ready", int'(ifa.in_ready), 4'b0100);
        cyc();
        iv[0] = '0;
        @(negedge clk);
        chk("t1_valid", int'(ifa.out_valid), 1);
        chk("t1_sel", int'(ifa.out_sel), 2);
        chk("t1_data", int'(ifa.out_data), 8'h22);

        // Fair rotation, one beat per cycle
        rst_pulse();
        iv[0] = 4'hF; il[0] = 4'hF; idat[0] = 32'h13121110; ordy[0] = 1'b1;
        loga.delete();
        repeat (9) @(negedge clk);
        #1;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(pack(1, k % 4, 8'h10 + k % 4));
        chk_log("t2", loga, exp_q);

        // Packet lock: req1 A1..A3 while req2 waits with B0
        rst_pulse();
        iv[0] = 4'b0110; idat[0] = 32'h00B0A100; il[0] = 4'b0100; ordy[0] = 1'b1;
        loga.delete();
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc0 = ifa.in_ready & iv[0];
            if (nb < 3) chk("t3_ready2", int'(ifa.in_ready[2]), 0);
            if (ifa.out_valid && (ifa.out_data == 8'hA1 || ifa.out_data == 8'hA2))
                chk("t3_busy", int'(busy_a), 1);
            if (ifa.out_valid && ifa.out_data == 8'hA3)
                chk("t3_busy_end", int'(busy_a), 0);
            cyc();
            if (acc0[1]) begin
                nb++;
                if (nb == 3) iv[0][1] = 1'b0;
                else begin
                    idat[0][15:8] = 8'(8'hA1 + nb);
                    il[0][1]      = (nb == 2);
                end
            end
            if (acc0[2]) iv[0][2] = 1'b0;
        end
        exp_q = '{pack(0, 1, 8'hA1), pack(0, 1, 8'hA2), pack(1, 1, 8'hA3), pack(1, 2, 8'hB0)};
        chk_log("t3", loga, exp_q);

        // Backpressure: three stalled cycles then resume
        rst_pulse();
        iv[0] = 4'hF; il[0] = 4'hF; idat[0] = 32'h43424140; ordy[0] = 1'b1;
        loga.delete();
        repeat (3) @(negedge clk);
        cyc();
        ordy[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(ifa.out_valid), 1);
            chk("t4_hold_data", int'(ifa.out_data), 8'h42);
            chk("t4_hold_sel", int'(ifa.out_sel), 2);
            chk("t4_hold_ready", int'(ifa.in_ready), 0);
        end
        cyc();
        ordy[0] = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(pack(1, k % 4, 8'h40 + k % 4));
        chk_log("t4", loga, exp_q);

        // Pointer wrap on DEPTH=3, in_last ignored when unlocked
        rst_pulse();
        iv[1] = 4'b0100; idat[1] = 32'h00C200C0; il[1] = 4'b0000; ordy[1] = 1'b1;
        logb.delete();
        @(negedge clk);
        cyc();
        iv[1] = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("t5_sel_range", (int'(ifb.out_sel) < 3) ? 1 : 0, 1);
        end
        #1;
        exp_q = '{pack(1, 2, 8'hC2), pack(1, 0, 8'hC0), pack(1, 2, 8'hC2), pack(1, 0, 8'hC0)};
        chk_log("t5", logb, exp_q);

        // Reset mid-packet
        rst_pulse();
        iv[0] = 4'b0010; il[0] = 4'b0000; idat[0] = 32'h00005500; ordy[0] = 1'b1;
        iv[1] = '0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("t6_busy_before", int'(busy_a), 1);
        chk("t6_valid_before", int'(ifa.out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy_clr", int'(busy_a), 0);
        chk("t6_valid_clr", int'(ifa.out_valid), 0);
        chk("t6_data_clr", int'(ifa.out_data), 0);
        chk("t6_sel_clr", int'(ifa.out_sel), 0);
        chk("t6_last_clr", int'(ifa.out_last), 0);
        chk("t6_ready_clr", int'(ifa.in_ready), 0);
        cyc();
        rst_n = 1'b1;
        iv[0] = 4'hF; il[0] = 4'hF; idat[0] = 32'h63626160;
        @(negedge clk);
        chk("t6_first_ready", int'(ifa.in_ready), 4'b0001);
        cyc();
        @(negedge clk);
        chk("t6_first_sel", int'(ifa.out_sel), 0);
        chk("t6_first_data", int'(ifa.out_data), 8'h60);

        // Random traffic with occasional asynchronous resets
        rst_pulse();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc0 = ifa.in_ready & iv[0];
            acc1 = {1'b0, ifb.in_ready} & iv[1];
            cyc();
            rst_n = ($urandom_range(0, 499) != 0);
            drive_rand(0, acc0);
            drive_rand(1, acc1);
        end
        rst_n = 1'b1;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
